// File: rtl/uart_fifo_regs.sv
// uart_fifo_regs
// Memory-mapped UART data/status register bank with parametrised TX and RX
// FIFOs, sticky overflow flags, flush strobes and a level interrupt.
//
// Ports:
//   clk_i        system clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   addr_i       register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL
//   we_i/re_i    CPU write / read strobes (both may be high in one cycle)
//   wdata_i      CPU write data
//   rdata_o      registered CPU read data, held until the next read
//   tx_data_o    head of the TX FIFO, 0 when empty
//   tx_valid_o   TX FIFO non-empty
//   tx_ready_i   transmitter takes the head when tx_valid_o is also high
//   rx_data_i    received character
//   rx_valid_i   push rx_data_i into the RX FIFO this cycle
//   irq_o        level interrupt, derived from registered state only
`timescale 1ns/1ps
module uart_fifo_regs #(
  parameter int W      = 32,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [W-1:0]      wdata_i,
  output logic [W-1:0]      rdata_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ADDR_TXDATA = 2'd0,
    ADDR_RXDATA = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_CTRL   = 2'd3
  } reg_addr_e;

  reg_addr_e addr;
  assign addr = reg_addr_e'(addr_i);

  // State
  logic [AW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [1:0]        ctrl_q, ctrl_d;     // [0] rx_irq_en, [1] tx_irq_en
  logic [W-1:0]      rdata_q, rdata_d;
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];

  // Flags
  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Events for this cycle
  logic tx_push, tx_pop, tx_flush, tx_push_ok, tx_drop;
  logic rx_push, rx_pop, rx_flush, rx_push_ok, rx_drop;
  logic ctrl_wr, status_wr;

  assign ctrl_wr   = we_i && (addr == ADDR_CTRL);
  assign status_wr = we_i && (addr == ADDR_STATUS);

  assign tx_push  = we_i && (addr == ADDR_TXDATA);
  assign tx_pop   = !tx_empty && tx_ready_i;
  assign tx_flush = ctrl_wr && wdata_i[2];
  // A concurrent pop frees a slot, so a full FIFO still accepts the push.
  assign tx_push_ok = tx_push && !tx_flush && (!tx_full || tx_pop);
  assign tx_drop    = tx_push && !tx_flush && tx_full && !tx_pop;

  // Reading an empty RXDATA is a no-op rather than a pop.
  assign rx_push  = rx_valid_i;
  assign rx_pop   = re_i && (addr == ADDR_RXDATA) && !rx_empty;
  assign rx_flush = ctrl_wr && wdata_i[3];
  assign rx_push_ok = rx_push && !rx_flush && (!rx_full || rx_pop);
  assign rx_drop    = rx_push && !rx_flush && rx_full && !rx_pop;

  // Read-side views
  logic [DATA_W-1:0] rx_head;
  logic [31:0]       status_word;

  assign rx_head = rx_empty ? '0 : rx_mem[rx_rptr_q];

  always_comb begin
    status_word        = '0;
    status_word[0]     = tx_full;
    status_word[1]     = tx_empty;
    status_word[2]     = rx_full;
    status_word[3]     = rx_empty;
    status_word[4]     = tx_ovf_q;
    status_word[5]     = rx_ovf_q;
    status_word[15:8]  = 8'(rx_cnt_q);
    status_word[23:16] = 8'(tx_cnt_q);
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    ctrl_d    = ctrl_q;
    rdata_d   = rdata_q;

    // Flush beats any push or pop in the same cycle.
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push_ok) tx_wptr_d = tx_wptr_q + AW'(1);
      if (tx_pop)     tx_rptr_d = tx_rptr_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop);
    end

    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push_ok) rx_wptr_d = rx_wptr_q + AW'(1);
      if (rx_pop)     rx_rptr_d = rx_rptr_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop);
    end

    if (ctrl_wr) ctrl_d = wdata_i[1:0];

    // Reads sample pre-edge state even when a write to the same address
    // happens in the same cycle.
    if (re_i) begin
      case (addr)
        ADDR_TXDATA: rdata_d = '0;
        ADDR_RXDATA: rdata_d = W'(rx_head);
        ADDR_STATUS: rdata_d = W'(status_word);
        ADDR_CTRL:   rdata_d = W'(ctrl_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // Sticky overflow: a new overflow wins over a same-cycle write-1-to-clear.
  assign tx_ovf_d = tx_drop || (tx_ovf_q && !(status_wr && wdata_i[4]));
  assign rx_ovf_d = rx_drop || (rx_ovf_q && !(status_wr && wdata_i[5]));

  // Control/status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
    end
  end

  // FIFO storage
  // NOTE: storage has no reset; the counts alone decide which entries are valid, so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (tx_push_ok) tx_mem[tx_wptr_q] <= wdata_i[DATA_W-1:0];
    if (rx_push_ok) rx_mem[rx_wptr_q] <= rx_data_i;
  end

  // Outputs
  assign rdata_o    = rdata_q;
  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rptr_q];
  assign irq_o      = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty)
                    || tx_ovf_q || rx_ovf_q;

  // Upper write-data bits carry no register fields.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

endmodule

// File: tb/tb_uart_fifo_regs.sv
`timescale 1ns/1ps
module tb_uart_fifo_regs;

  localparam int W      = 32;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        addr_i = '0;
  logic              we_i = 1'b0;
  logic              re_i = 1'b0;
  logic [W-1:0]      wdata_i = '0;
  logic [W-1:0]      rdata_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i = 1'b0;
  logic [DATA_W-1:0] rx_data_i = '0;
  logic              rx_valid_i = 1'b0;
  logic              irq_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  uart_fifo_regs #(.W(W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .irq_o      (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (queues) ----------------
  logic [7:0]  m_tx_q[$];
  logic [7:0]  m_rx_q[$];
  bit          m_tx_ovf, m_rx_ovf, m_rx_ien, m_tx_ien;
  logic [31:0] m_rdata;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_tx_q.size() == DEPTH);
    s[1]     = (m_tx_q.size() == 0);
    s[2]     = (m_rx_q.size() == DEPTH);
    s[3]     = (m_rx_q.size() == 0);
    s[4]     = m_tx_ovf;
    s[5]     = m_rx_ovf;
    s[15:8]  = 8'(m_rx_q.size());
    s[23:16] = 8'(m_tx_q.size());
    return s;
  endfunction

  always @(posedge clk) begin
    bit tx_pop, rx_pop, tx_fl, rx_fl, tx_wr, tx_lost, rx_lost;
    if (rst_i) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_tx_ovf = 0; m_rx_ovf = 0; m_rx_ien = 0; m_tx_ien = 0;
      m_rdata  = '0;
    end else begin
      if (re_i) begin
        case (addr_i)
          2'd0: m_rdata = '0;
          2'd1: m_rdata = (m_rx_q.size() != 0) ? {24'h0, m_rx_q[0]} : '0;
          2'd2: m_rdata = model_status();
          default: m_rdata = {30'h0, m_tx_ien, m_rx_ien};
        endcase
      end
      tx_pop  = (m_tx_q.size() != 0) && tx_ready_i;
      rx_pop  = re_i && (addr_i == 2'd1) && (m_rx_q.size() != 0);
      tx_fl   = we_i && (addr_i == 2'd3) && wdata_i[2];
      rx_fl   = we_i && (addr_i == 2'd3) && wdata_i[3];
      tx_wr   = we_i && (addr_i == 2'd0);
      tx_lost = tx_wr && !tx_fl && (m_tx_q.size() == DEPTH) && !tx_pop;
      rx_lost = rx_valid_i && !rx_fl && (m_rx_q.size() == DEPTH) && !rx_pop;
      if (we_i && addr_i == 2'd2) begin
        if (wdata_i[4]) m_tx_ovf = 0;
        if (wdata_i[5]) m_rx_ovf = 0;
      end
      if (tx_lost) m_tx_ovf = 1;
      if (rx_lost) m_rx_ovf = 1;
      if (we_i && addr_i == 2'd3) begin
        m_rx_ien = wdata_i[0];
        m_tx_ien = wdata_i[1];
      end
      if (tx_fl) m_tx_q.delete();
      else begin
        if (tx_pop) void'(m_tx_q.pop_front());
        if (tx_wr && !tx_lost) m_tx_q.push_back(wdata_i[7:0]);
      end
      if (rx_fl) m_rx_q.delete();
      else begin
        if (rx_pop) void'(m_rx_q.pop_front());
        if (rx_valid_i && !rx_lost) m_rx_q.push_back(rx_data_i);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_valid", {31'h0, tx_valid_o}, {31'h0, m_tx_q.size() != 0});
      check("tx_data", {24'h0, tx_data_o}, (m_tx_q.size() != 0) ? {24'h0, m_tx_q[0]} : 32'h0);
      check("rdata", rdata_o, m_rdata);
      check("irq", {31'h0, irq_o},
            {31'h0, (m_rx_ien && m_rx_q.size() != 0) || (m_tx_ien && m_tx_q.size() == 0)
                    || m_tx_ovf || m_rx_ovf});
    end
  end

  // ---------------- Stimulus helpers (called at negedge) ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0; wdata_i = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    re_i = 1'b1; addr_i = a;
    tick();
    re_i = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid_i = 1'b1; rx_data_i = d;
    tick();
    rx_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst_i = 1'b0;

    // Reset state
    rd(2'd2);
    check("reset_status", rdata_o, 32'h0000_000A);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    check("reset_tx_valid", {31'h0, tx_valid_o}, 32'h0);

    // TX overflow then drain
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h41 + i);
    rd(2'd2);
    check("tx_full_status", rdata_o, 32'h0004_0019);
    check("tx_ovf_irq", {31'h0, irq_o}, 32'h1);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tx_drain_data", {24'h0, tx_data_o}, 32'h41 + i);
      tick();
    end
    check("tx_drained_valid", {31'h0, tx_valid_o}, 32'h0);
    tx_ready_i = 1'b0;
    wr(2'd2, 32'h10);

    // RX with pointer wrap, then read past empty
    rx_push(8'h01);
    rx_push(8'h02);
    rd(2'd1);
    check("rx_pre1", rdata_o, 32'h01);
    rd(2'd1);
    check("rx_pre2", rdata_o, 32'h02);
    wr(2'd0, 32'h5A);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) rx_push(8'(i * 16));
    for (int i = 1; i <= 4; i++) begin
      rd(2'd1);
      check("rx_wrap_data", rdata_o, 32'(i * 16));
    end
    rd(2'd1);
    check("rx_empty_read", rdata_o, 32'h0);
    rd(2'd2);
    check("rx_empty_status", rdata_o, 32'h0000_000A);

    // Full RX: push and pop in one cycle
    for (int i = 0; i < 4; i++) rx_push(8'hA1 + 8'(i));
    rx_valid_i = 1'b1; rx_data_i = 8'h55; re_i = 1'b1; addr_i = 2'd1;
    tick();
    rx_valid_i = 1'b0; re_i = 1'b0;
    check("rx_full_pushpop", rdata_o, 32'hA1);
    rd(2'd2);
    check("rx_full_status", rdata_o, 32'h0000_0406);
    for (int i = 0; i < 3; i++) rd(2'd1);
    check("rx_a4", rdata_o, 32'hA4);
    rd(2'd1);
    check("rx_55_last", rdata_o, 32'h55);

    // RX interrupt and overflow handling
    wr(2'd3, 32'h1);
    check("irq_idle", {31'h0, irq_o}, 32'h0);
    rx_push(8'h77);
    check("irq_rx", {31'h0, irq_o}, 32'h1);
    rd(2'd1);
    check("irq_rx_read", rdata_o, 32'h77);
    check("irq_rx_clear", {31'h0, irq_o}, 32'h0);
    for (int i = 0; i < 5; i++) rx_push(8'h80 + 8'(i));
    rd(2'd2);
    check("rx_ovf_status", rdata_o, 32'h0000_0426);
    wr(2'd2, 32'h20);
    rd(2'd2);
    check("rx_ovf_w1c", rdata_o, 32'h0000_0406);
    rx_valid_i = 1'b1; rx_data_i = 8'h99;
    wr(2'd2, 32'h20);
    rx_valid_i = 1'b0;
    rd(2'd2);
    check("rx_ovf_set_wins", rdata_o, 32'h0000_0426);
    wr(2'd2, 32'h20);
    rx_valid_i = 1'b1; rx_data_i = 8'h99;
    wr(2'd3, 32'h8);
    rx_valid_i = 1'b0;
    rd(2'd2);
    check("rx_flush_status", rdata_o, 32'h0000_000A);

    // TX irq enable and simultaneous read/write of CTRL
    wr(2'd3, 32'h2);
    check("irq_tx_empty", {31'h0, irq_o}, 32'h1);
    we_i = 1'b1; re_i = 1'b1; addr_i = 2'd3; wdata_i = 32'h1;
    tick();
    we_i = 1'b0; re_i = 1'b0;
    check("rw_same_cycle", rdata_o, 32'h2);
    rd(2'd3);
    check("ctrl_readback", rdata_o, 32'h1);
    wr(2'd3, 32'h0);

    // TX flush beats a concurrent pop
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h61 + i);
    tx_ready_i = 1'b1;
    wr(2'd3, 32'h4);
    check("tx_flush_valid", {31'h0, tx_valid_o}, 32'h0);
    tx_ready_i = 1'b0;
    rd(2'd2);
    check("tx_flush_status", rdata_o, 32'h0000_000A);
    rd(2'd3);
    check("ctrl_strobe_read", rdata_o, 32'h0);

    // Reset with both FIFOs holding data
    wr(2'd0, 32'h71);
    wr(2'd0, 32'h72);
    rx_push(8'h33);
    rx_push(8'h34);
    rd(2'd2);
    check("pre_reset_status", rdata_o, 32'h0002_0200);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("post_reset_valid", {31'h0, tx_valid_o}, 32'h0);
    check("post_reset_rdata", rdata_o, 32'h0);
    rd(2'd2);
    check("post_reset_status", rdata_o, 32'h0000_000A);

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_regs.md
Name: uart_fifo_regs

Overview:
Memory-mapped UART data/status register bank for the mono-cycle CPU peripheral bus. It replaces the fixed two-register TX/RX data holder with parametrised TX and RX FIFOs, status flags, sticky overflow bits, flush control and an interrupt output. The CPU side is a simple addressed read/write port. The UART side is a valid/ready pop interface for TX and a valid-only push for RX.

Parameters:
W, 32, CPU data bus width.
DATA_W, 8, UART character width; DATA_W <= 8 and DATA_W <= W.
DEPTH, 4, entries per FIFO; power of 2, range 2..128.

Ports:
clk_i  in  1  system clock; all state updates on the rising edge.
rst_i  in  1  reset, synchronous, active-high.
addr_i  in  2  register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
we_i  in  1  CPU write strobe.
re_i  in  1  CPU read strobe.
wdata_i  in  W  CPU write data.
rdata_o  out  W  CPU read data; registered.
tx_data_o  out  DATA_W  head of TX FIFO; 0 when the FIFO is empty.
tx_valid_o  out  1  TX FIFO non-empty.
tx_ready_i  in  1  UART transmitter accepts the head; pop when tx_valid_o and tx_ready_i are both high.
rx_data_i  in  DATA_W  received character.
rx_valid_i  in  1  push rx_data_i into the RX FIFO (one cycle per character).
irq_o  out  1  interrupt request; level-sensitive.

Behaviour:
- Reset (rst_i=1 at an edge): both FIFOs empty (pointers and counts 0), CTRL=0, sticky bits 0. Outputs rdata_o=0, tx_valid_o=0, tx_data_o=0, irq_o=0. A reset mid-transfer discards all FIFO contents at that edge.
- Counts are clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- rdata_o: a read with re_i=1 in cycle N returns its value at edge N+1. rdata_o holds that value until the next read. Unused upper bits are 0.
- TXDATA (addr 0):
  - Write: push wdata_i[DATA_W-1:0].
  - If the FIFO is full with no pop in the same cycle, the write is dropped and tx_ovf is set.
  - A read returns 0.
- RXDATA (addr 1):
  - Read: returns the head zero-extended and pops it.
  - A read when empty returns 0 with no state change.
  - A write is ignored.
- STATUS (addr 2), read fields:
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
  - bit4 tx_ovf, bit5 rx_ovf.
  - [15:8] rx_count, [23:16] tx_count; all other bits 0.
  - Write: write-1-to-clear bits 4 and 5; all other bits are ignored.
- CTRL (addr 3):
  - bit0 rx_irq_en, bit1 tx_irq_en: read/write.
  - bit2 tx_flush, bit3 rx_flush: write-only strobes, always read 0.
- RX push: rx_valid_i=1 when full with no CPU pop in the same cycle drops the character and sets rx_ovf.
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO: both succeed, count unchanged, no overflow.
  - On an empty FIFO: the pop is a no-op (read returns 0, no bypass) and the push succeeds, so count becomes 1.
  - Flush has priority over any push or pop in the same cycle. Count becomes 0 and the concurrent push is discarded. The overflow bit is not set by the discarded push.
  - A STATUS W1C write in the same cycle as a new overflow event leaves the bit set (set wins).
  - we_i and re_i both high: the read samples pre-edge state and the write executes. Both act on addr_i.
- irq_o = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty) | tx_ovf | rx_ovf. It is derived only from registered state and has no combinational path from the inputs.
- tx_data_o is driven from FIFO storage at the read pointer, gated to 0 when empty. It changes only at clock edges.

Test Plan:
- Reset then read STATUS -> rdata_o=0x0000_000A (tx_empty, rx_empty); irq_o=0; tx_valid_o=0.
- DEPTH=4, tx_ready_i=0; write TXDATA 0x41,0x42,0x43,0x44,0x45 -> STATUS tx_full=1, tx_count=4, tx_ovf=1. Then tx_ready_i=1 for 4 cycles -> tx_data_o sequence 0x41..0x44, then tx_valid_o=0.
- Push RX 0x10,0x20,0x30,0x40 with CPU writing/reading in between to force pointer wrap, then read RXDATA 5 times -> 0x10,0x20,0x30,0x40, then 0 with rx_empty=1 and no underflow side effect.
- RX full; same cycle rx_valid_i=1 with data 0x55 and a RXDATA read -> head returned, count stays 4, rx_ovf=0; 0x55 is last out.
- CTRL=0x1, push one RX byte -> irq_o=1 the cycle after the push edge; read RXDATA -> irq_o=0. Set rx_ovf, write STATUS 0x20 -> rx_ovf=0.
- TX holds 3 entries; write CTRL=0x4 while tx_ready_i=1 -> tx_count=0, tx_valid_o=0 next cycle, CTRL reads 0x0. Assert rst_i with both FIFOs non-empty -> all counts 0 next edge.
